// File: rtl/dual_port_ram_psr_if.sv
// Bus bundle for dual_port_ram_psr: fetch port, load/store data port and status.
// The memory side takes the slave modport; the requester side takes master.
interface dual_port_ram_psr_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 12
);
    logic              iFetchReq;
    logic [ADDR_W-1:0] iFetchAddr;
    logic              oFetchValid;
    logic [DATA_W-1:0] oFetchData;
    logic              iMemReq;
    logic              iMemWe;
    logic [ADDR_W-1:0] iMemAddr;
    logic [DATA_W-1:0] iMemData;
    logic              oMemValid;
    logic [DATA_W-1:0] oMemData;
    logic              oReady;
    logic              oAddrErr;
    logic [4:0]        oPSR;

    modport master (
        output iFetchReq, iFetchAddr, iMemReq, iMemWe, iMemAddr, iMemData,
        input  oFetchValid, oFetchData, oMemValid, oMemData, oReady, oAddrErr, oPSR
    );

    modport slave (
        input  iFetchReq, iFetchAddr, iMemReq, iMemWe, iMemAddr, iMemData,
        output oFetchValid, oFetchData, oMemValid, oMemData, oReady, oAddrErr, oPSR
    );
endinterface

// File: rtl/dual_port_ram_psr.sv
// Dual-port RAM (read-only fetch port + read/write data port) with a hardware
// zero-fill after reset and PSR flags derived from each data-port read.
module dual_port_ram_psr #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 1024,
    parameter int PSR_W  = 13
) (
    input logic              iClk,
    input logic              iReset,
    dual_port_ram_psr_if.slave bus
);
    localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t           state, stateNxt;
    logic [CNT_W-1:0] clrCnt, clrCntNxt;
    logic             ready;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              fetchAcc, memAcc, memRd, memWr;
    logic              fetchIn, memIn;
    logic              wrEn;
    logic [CNT_W-1:0]  wrAddr;
    logic [DATA_W-1:0] wrData;
    logic [DATA_W-1:0] fetchWord, memWord;

    logic              fetchVld, memVld, addrErr;
    logic [DATA_W-1:0] fetchData, memData;
    logic [PSR_W-1:0]  psrF;

    function automatic logic inRange(input logic [ADDR_W-1:0] a);
        return (ADDR_W+1)'(a) < (ADDR_W+1)'(DEPTH);
    endfunction

    always_ff @(posedge iClk) begin
        if (iReset) begin
            state  <= CLEAR;
            clrCnt <= '0;
        end else begin
            state  <= stateNxt;
            clrCnt <= clrCntNxt;
        end
    end

    always_comb begin
        stateNxt  = state;
        clrCntNxt = clrCnt;
        case (state)
            CLEAR: begin
                clrCntNxt = clrCnt + 1'b1;
                if (clrCnt == LAST) begin
                    stateNxt  = RUN;
                    clrCntNxt = '0;
                end
            end
            RUN: ;
            default: stateNxt = CLEAR;
        endcase
    end

    // Reset overrides RUN combinationally so nothing is accepted on the reset edge.
    assign ready    = (state == RUN) && !iReset;
    assign fetchAcc = bus.iFetchReq && ready;
    assign memAcc   = bus.iMemReq && ready;
    assign memRd    = memAcc && !bus.iMemWe;
    assign memWr    = memAcc && bus.iMemWe;
    assign fetchIn  = inRange(bus.iFetchAddr);
    assign memIn    = inRange(bus.iMemAddr);

    // Single write port shared between the clear sweep and data-port stores.
    always_comb begin
        wrEn   = 1'b0;
        wrAddr = clrCnt;
        wrData = '0;
        if (state == CLEAR) begin
            wrEn = !iReset;
        end else if (memWr && memIn) begin
            wrEn   = 1'b1;
            wrAddr = bus.iMemAddr[CNT_W-1:0];
            wrData = bus.iMemData;
        end
    end

    // Reads sample the array before this edge's write lands: read-before-write.
    assign fetchWord = fetchIn ? mem[bus.iFetchAddr[CNT_W-1:0]] : '0;
    assign memWord   = memIn   ? mem[bus.iMemAddr[CNT_W-1:0]]   : '0;

    always_ff @(posedge iClk) begin
        if (wrEn) mem[wrAddr] <= wrData;
    end

    always_ff @(posedge iClk) begin
        if (iReset) begin
            fetchVld  <= 1'b0;
            fetchData <= '0;
            memVld    <= 1'b0;
            memData   <= '0;
            addrErr   <= 1'b0;
            psrF      <= '0;
        end else begin
            fetchVld <= fetchAcc;
            memVld   <= memRd;
            addrErr  <= (fetchAcc && !fetchIn) || (memAcc && !memIn);
            if (fetchAcc) fetchData <= fetchWord;
            if (memRd) begin
                memData <= memWord;
                psrF    <= memWord[PSR_W-1:0];
            end
        end
    end

    assign bus.oReady      = ready;
    assign bus.oFetchValid = fetchVld;
    assign bus.oFetchData  = fetchData;
    assign bus.oMemValid   = memVld;
    assign bus.oMemData    = memData;
    assign bus.oAddrErr    = addrErr;
    // Flag order {n, z, p, e, c}.
    assign bus.oPSR = {psrF[PSR_W-2], (psrF == '0), ^psrF, ~psrF[0], psrF[PSR_W-1]};
endmodule

// File: tb/tb_dual_port_ram_psr.sv
// Directed bench for dual_port_ram_psr: clear sequence, data/fetch ports,
// same-address conflicts, out-of-range accesses and reset during clear.
module tb_dual_port_ram_psr;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 12;
    localparam int DEPTH  = 1024;
    localparam int PSR_W  = 13;

    logic iClk = 1'b0;
    logic iReset = 1'b1;
    always #5 iClk = ~iClk;

    dual_port_ram_psr_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    dual_port_ram_psr #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .PSR_W(PSR_W)) dut (
        .iClk  (iClk),
        .iReset(iReset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge iClk);
    endtask

    task automatic idleIn();
        bus.iFetchReq  = 1'b0;
        bus.iFetchAddr = '0;
        bus.iMemReq    = 1'b0;
        bus.iMemWe     = 1'b0;
        bus.iMemAddr   = '0;
        bus.iMemData   = '0;
    endtask

    task automatic memWrite(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bus.iMemReq = 1'b1; bus.iMemWe = 1'b1; bus.iMemAddr = a; bus.iMemData = d;
        cyc();
        bus.iMemReq = 1'b0; bus.iMemWe = 1'b0;
    endtask

    task automatic memRead(input logic [ADDR_W-1:0] a);
        bus.iMemReq = 1'b1; bus.iMemWe = 1'b0; bus.iMemAddr = a;
        cyc();
        bus.iMemReq = 1'b0;
    endtask

    task automatic fetch(input logic [ADDR_W-1:0] a);
        bus.iFetchReq = 1'b1; bus.iFetchAddr = a;
        cyc();
        bus.iFetchReq = 1'b0;
    endtask

    initial begin
        int n;
        int vpulses;
        int readyHigh;
        idleIn();
        iReset = 1'b1;
        cyc(); cyc();
        chk("rst_ready",  bus.oReady, 0);
        chk("rst_fvalid", bus.oFetchValid, 0);
        chk("rst_mvalid", bus.oMemValid, 0);
        chk("rst_fdata",  bus.oFetchData, 0);
        chk("rst_mdata",  bus.oMemData, 0);
        chk("rst_aerr",   bus.oAddrErr, 0);
        chk("rst_psr",    bus.oPSR, 5'b01010);

        // Clear length after a reset release
        iReset = 1'b0;
        n = 0;
        while (!bus.oReady && n < 3000) begin n++; cyc(); end
        chk("clear_len", n, 1024);
        chk("ready_run", bus.oReady, 1);

        memRead(12'h000);
        chk("rd000_valid", bus.oMemValid, 1);
        chk("rd000_data",  bus.oMemData, 0);
        chk("rd000_aerr",  bus.oAddrErr, 0);
        memRead(12'h3FF);
        chk("rd3ff_data",  bus.oMemData, 0);
        bus.iFetchReq = 1'b1; bus.iFetchAddr = 12'h155;
        memRead(12'h155);
        bus.iFetchReq = 1'b0;
        chk("rd155_data",  bus.oMemData, 0);
        chk("f155_valid",  bus.oFetchValid, 1);
        chk("f155_data",   bus.oFetchData, 0);
        chk("clr_psr",     bus.oPSR, 5'b01010);

        // Write then read, PSR derivation
        memWrite(12'h010, 32'h0000_1801);
        chk("wr_novalid", bus.oMemValid, 0);
        chk("wr_psr_hold", bus.oPSR, 5'b01010);
        memRead(12'h010);
        chk("rd010_valid", bus.oMemValid, 1);
        chk("rd010_data",  bus.oMemData, 32'h0000_1801);
        chk("rd010_psr",   bus.oPSR, 5'b10101);
        cyc();
        chk("mvalid_drop", bus.oMemValid, 0);

        // Back-to-back fetch
        for (int i = 0; i < 8; i++) memWrite(ADDR_W'(i), DATA_W'(i));
        for (int i = 0; i < 8; i++) begin
            bus.iFetchReq = 1'b1; bus.iFetchAddr = ADDR_W'(i);
            cyc();
            chk("b2b_valid", bus.oFetchValid, 1);
            chk("b2b_data",  bus.oFetchData, 64'(i));
        end
        bus.iFetchReq = 1'b0;
        cyc();
        chk("b2b_end_valid", bus.oFetchValid, 0);
        chk("b2b_hold_data", bus.oFetchData, 7);
        chk("b2b_psr_hold",  bus.oPSR, 5'b10101);

        // Same-address write + fetch: old word first
        memWrite(12'h020, 32'hAAAA_AAAA);
        bus.iFetchReq = 1'b1; bus.iFetchAddr = 12'h020;
        memWrite(12'h020, 32'h5555_5555);
        bus.iFetchReq = 1'b0;
        chk("rbw_old",   bus.oFetchData, 32'hAAAA_AAAA);
        fetch(12'h020);
        chk("rbw_new",   bus.oFetchData, 32'h5555_5555);
        bus.iFetchReq = 1'b1; bus.iFetchAddr = 12'h020;
        memRead(12'h020);
        bus.iFetchReq = 1'b0;
        chk("dual_fetch", bus.oFetchData, 32'h5555_5555);
        chk("dual_mem",   bus.oMemData, 32'h5555_5555);
        chk("dual_psr",   bus.oPSR, 5'b00101);

        // Out of range: suppressed write, no aliasing, zero read
        memWrite(12'h000, 32'h1234_5678);
        chk("inr_aerr", bus.oAddrErr, 0);
        memWrite(12'h400, 32'hDEAD_BEEF);
        chk("oor_wr_aerr", bus.oAddrErr, 1);
        chk("oor_wr_nov",  bus.oMemValid, 0);
        cyc();
        chk("oor_aerr_pulse", bus.oAddrErr, 0);
        memRead(12'h000);
        chk("oor_noalias", bus.oMemData, 32'h1234_5678);
        chk("psr_5678",    bus.oPSR, 5'b00111);
        memRead(12'h400);
        chk("oor_rd_valid", bus.oMemValid, 1);
        chk("oor_rd_data",  bus.oMemData, 0);
        chk("oor_rd_aerr",  bus.oAddrErr, 1);
        chk("oor_rd_psr",   bus.oPSR, 5'b01010);
        fetch(12'h7FF);
        chk("oor_f_valid", bus.oFetchValid, 1);
        chk("oor_f_data",  bus.oFetchData, 0);
        chk("oor_f_aerr",  bus.oAddrErr, 1);

        // Reset mid-clear with requests held during CLEAR
        iReset = 1'b1;
        cyc();
        iReset = 1'b0;
        bus.iFetchReq = 1'b1; bus.iFetchAddr = 12'h010;
        bus.iMemReq = 1'b1; bus.iMemWe = 1'b0; bus.iMemAddr = 12'h010;
        vpulses = 0;
        readyHigh = 0;
        for (int k = 0; k < 500; k++) begin
            cyc();
            if (bus.oFetchValid || bus.oMemValid) vpulses++;
            if (bus.oReady) readyHigh++;
        end
        chk("midclr_ready_low", readyHigh, 0);
        iReset = 1'b1;
        cyc();
        iReset = 1'b0;
        n = 0;
        while (!bus.oReady && n < 3000) begin
            if (bus.oFetchValid || bus.oMemValid) vpulses++;
            n++;
            cyc();
        end
        idleIn();
        chk("reclear_len", n, 1024);
        chk("clear_nopulse", vpulses, 0);
        memRead(12'h010);
        chk("reclear_data", bus.oMemData, 0);
        chk("reclear_psr",  bus.oPSR, 5'b01010);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dual_port_ram_psr.md
Name: dual_port_ram_psr

Overview:
- Parametrised successor to the single-array program/data memory.
- Synchronous dual-port RAM with two ports:
  - Fetch port: read-only, driven by the PC.
  - Data port: read/write, driven by the load/store path.
- Registered PSR flags are derived from each data-port read.
- After every reset, a hardware clear sequence zero-fills the array before any access is accepted.

Parameters:
- DATA_W, 32, data word width.
- ADDR_W, 12, address width on both ports.
- DEPTH, 1024, number of implemented words; DEPTH <= 2**ADDR_W.
- PSR_W, 13, width of the low data field used for flag derivation; 2 <= PSR_W <= DATA_W.

Ports:
- iClk  in  1  clock; all state changes on rising edge.
- iReset  in  1  synchronous, active-high reset.
- iFetchReq  in  1  fetch read request.
- iFetchAddr  in  ADDR_W  fetch address.
- oFetchValid  out  1  oFetchData valid this cycle.
- oFetchData  out  DATA_W  fetch read data.
- iMemReq  in  1  data-port request.
- iMemWe  in  1  1 = write, 0 = read; qualified by iMemReq.
- iMemAddr  in  ADDR_W  data-port address.
- iMemData  in  DATA_W  write data.
- oMemValid  out  1  oMemData valid (read responses only).
- oMemData  out  DATA_W  data-port read data.
- oReady  out  1  block accepts requests this cycle.
- oAddrErr  out  1  one-cycle pulse on an out-of-range access, either port.
- oPSR  out  5  flags: [0] c, [1] e, [2] p, [3] z, [4] n.

Behaviour:
- Reset and clear:
  - One clock (iClk); reset is synchronous and active-high (iReset).
  - While iReset is high, enter CLEAR with clear counter = 0.
  - While iReset is high, all outputs reset: oReady=0, oFetchValid=0, oMemValid=0, oFetchData=0, oMemData=0, oAddrErr=0.
  - PSR field register resets to 0, so oPSR = 5'b01010 (e=1, z=1).
- State machine, two states:
  - CLEAR: writes 0 to mem[counter] each cycle and increments the counter. After the write to DEPTH-1, go to RUN on the next edge, so CLEAR lasts exactly DEPTH cycles after reset release. oReady=0 throughout. iFetchReq and iMemReq are ignored; no valid pulses are produced.
  - RUN: oReady=1. Stays in RUN until iReset.
  - iReset asserted in either state, including mid-clear, restarts CLEAR from address 0.
- Fetch port:
  - A request accepted in cycle N (iFetchReq & oReady) gives oFetchValid=1 with oFetchData = mem[iFetchAddr] in cycle N+1.
  - Fully pipelined: one request per cycle, back-to-back allowed.
  - oFetchData holds its last value when oFetchValid=0.
- Data port:
  - Write (iMemReq & iMemWe & oReady): mem[iMemAddr] <= iMemData at the edge. No response; oMemValid stays 0.
  - Read (iMemReq & ~iMemWe & oReady): oMemValid=1 and oMemData = mem[iMemAddr] in cycle N+1.
  - On every data read response, the PSR field register loads the low PSR_W bits of the read data. It holds otherwise; writes and fetches never change the PSR.
- Flag definitions (combinational from the PSR field register F):
  - c = F[PSR_W-1]
  - n = F[PSR_W-2]
  - e = ~F[0]
  - p = XOR-reduce of F
  - z = (F == 0)
- Simultaneous access to the same address:
  - Data-port write plus fetch read in the same cycle: read-before-write, so the fetch returns the old word and the new word is visible from the next request.
  - Two reads to the same address: both return the same word.
- Out of range (address >= DEPTH) on either port:
  - Write: suppressed.
  - Read: returns 0 with the corresponding valid still asserted, so a data read loads PSR F=0.
  - oAddrErr=1 in cycle N+1; it is the OR over both ports.
- Requests with oReady=0 are dropped, not queued. Requesters must hold or retry.

Test Plan:
- Clear sequence: pulse iReset for 1 cycle, DEPTH=1024 → oReady=0 for exactly 1024 cycles, then 1. Reading 0x000, 0x3FF and 0x155 returns 0, and oPSR=5'b01010.
- Write then read on the data port: write 0x0000_1801 to 0x010, read 0x010 → oMemValid one cycle after the read, oMemData=0x0000_1801. F=0x1801 gives oPSR c=1, n=1, e=0, p=1, z=0 = 5'b10101.
- Back-to-back fetch: fetch 0x000..0x007 on consecutive cycles after preloading the values 0..7 → oFetchValid high for 8 consecutive cycles with data 0..7 in order.
- Same-address conflict: preload 0x020 = 0xAAAA_AAAA. In one cycle, data write 0x5555_5555 to 0x020 and fetch 0x020 → fetch returns 0xAAAA_AAAA. A fetch on the next cycle returns 0x5555_5555.
- Out of range: write 0xDEAD_BEEF to 0x400, then read 0x400 → write suppressed, read returns 0, oAddrErr pulses once per access, and oPSR becomes 5'b01010.
- Reset mid-clear: assert iReset at clear cycle 500 → clear restarts, oReady rises 1024 cycles after the release, and requests issued during CLEAR produce no valid pulses.
